// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz raster constants, RRRGGGBB field layout and the
// colour-expansion helper used by the VGA timing generator.
package vga_timing_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam bit SYNC_POL_DEFAULT    = 1'b0;
    localparam int PIX_LATENCY_DEFAULT = 2;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } sync_bits_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Bit replication spreads the short fields over the full 0..255 DAC range.
    function automatic rgb888_t expand_rgb332(input logic [7:0] color);
        logic [2:0] r3;
        logic [2:0] g3;
        logic [1:0] b2;
        rgb888_t    rgb;
        r3    = color[R_MSB:R_LSB];
        g3    = color[G_MSB:G_LSB];
        b2    = color[B_MSB:B_LSB];
        rgb.r = {r3, r3, r3[2:1]};
        rgb.g = {g3, g3, g3[2:1]};
        rgb.b = {b2, b2, b2, b2};
        return rgb;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that realigns the raw sync/active bits with the
// renderer's pixel pipeline; depth 0 degenerates to a wire.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // NOTE: every stage is reset (unlike a RAM) so no stale sync or
            // active bit can reach the pins in the clocks after reset release.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running x/y counters, sync/blank delayed to match
// the renderer latency, registered DAC and sync pins, and a per-frame tick.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int H_FP        = vga_timing_pkg::H_FP,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_BP        = vga_timing_pkg::H_BP,
    parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int V_FP        = vga_timing_pkg::V_FP,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_BP        = vga_timing_pkg::V_BP,
    parameter int PIX_LATENCY = PIX_LATENCY_DEFAULT,
    parameter bit SYNC_POL    = SYNC_POL_DEFAULT
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic [7:0] pixel_color,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       frame_tick,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_sync_n
);

    localparam int HT  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HSS = H_VISIBLE + H_FP;
    localparam int HSE = HSS + H_SYNC;
    localparam int VSS = V_VISIBLE + V_FP;
    localparam int VSE = VSS + V_SYNC;

    logic       x_last;
    logic       y_last;
    sync_bits_t raw;
    sync_bits_t dly;
    rgb888_t    rgb;

    assign x_last = (x == 10'(HT - 1));
    assign y_last = (y == 10'(VT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            frame_tick <= 1'b0;
        end else begin
            x <= x_last ? '0 : x + 10'd1;
            if (x_last) y <= y_last ? '0 : y + 10'd1;
            // Registered off the pre-wrap state so it coincides with (0, V_VISIBLE).
            frame_tick <= x_last && (y == 10'(V_VISIBLE - 1));
        end
    end

    assign video_on = (x < 10'(H_VISIBLE)) && (y < 10'(V_VISIBLE));
    assign raw.hs   = (x >= 10'(HSS)) && (x < 10'(HSE));
    assign raw.vs   = (y >= 10'(VSS)) && (y < 10'(VSE));
    assign raw.act  = video_on;

    vga_sync_delay #(
        .DEPTH     (PIX_LATENCY),
        .WIDTH     (3),
        .RESET_VAL (3'b000)
    ) u_sync_delay (
        .clk (vga_clk),
        .rst (rst),
        .d   (raw),
        .q   (dly)
    );

    assign rgb = expand_rgb332(pixel_color);

    // Gating on the delayed active bit keeps blanking-time garbage off the DAC.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            vga_hs      <= ~SYNC_POL;
            vga_vs      <= ~SYNC_POL;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            vga_hs      <= dly.hs ~^ SYNC_POL;
            vga_vs      <= dly.vs ~^ SYNC_POL;
            vga_blank_n <= dly.act;
            vga_r       <= dly.act ? rgb.r : 8'h00;
            vga_g       <= dly.act ? rgb.g : 8'h00;
            vga_b       <= dly.act ? rgb.b : 8'h00;
        end
    end

    assign vga_sync_n = 1'b0;

endmodule
